// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: blanked slots, leading-zero
// suppression and a shadow/active register pair so frames never tear.
module sseg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DIV         = 1000,
  parameter int ON_TICKS    = 15,
  parameter int BLANK_TICKS = 1,
  parameter int INV_DIG     = 1,
  parameter int LZS         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       data,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic [DIGITS-1:0]         blank_mask,
  output logic                      load_ack,
  output logic [3:0]                num,
  output logic                      dp,
  output logic [DIGITS-1:0]         dig,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done
);
  localparam int IW   = $clog2(DIGITS);
  localparam int PW   = $clog2(DIV);
  localparam int MAXT = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [PW-1:0]     DIV_LAST   = PW'(DIV - 1);
  localparam logic [TW-1:0]     ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]     BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_OFF    = (INV_DIG != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]     act_mask_q, act_mask_d, sh_mask_q, sh_mask_d;
  logic                  pend_q, pend_d;
  logic [3:0]            num_q, num_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic [DIGITS-1:0]     supp_d;
  logic                  tick, boundary, commit;

  // A digit is dark when masked, or when it and every more significant nibble
  // are zero; digit 0 always shows so a zero value still reads "0".
  function automatic logic [DIGITS-1:0] suppressed(input logic [4*DIGITS-1:0] d,
                                                   input logic [DIGITS-1:0]   m);
    logic zero_above;
    suppressed = m;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (d[4*k +: 4] == 4'd0);
      if ((LZS != 0) && zero_above) suppressed[k] = 1'b1;
    end
  endfunction

  always_comb begin
    tick     = (cnt_q == DIV_LAST);
    boundary = en && tick && (state_q == S_ON) && (tcnt_q == ON_LAST) && (idx_q == IDX_LAST);
    commit   = boundary && (pend_q || load);

    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    if (tick) begin
      case (state_q)
        S_BLANK: begin
          if (tcnt_q == BLANK_LAST) begin
            state_d = S_ON;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
          if (tcnt_q == ON_LAST) begin
            state_d = S_BLANK;
            tcnt_d  = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      endcase
    end
    if (!en) begin
      cnt_d   = '0;
      tcnt_d  = '0;
      idx_d   = '0;
      state_d = S_BLANK;
    end

    // Shadow capture keeps running while scanning is stopped; only a frame
    // boundary may move it into the displayed set.
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_mask_d = sh_mask_q;
    if (load) begin
      sh_data_d = data;
      sh_dp_d   = dp_in;
      sh_mask_d = blank_mask;
    end
    pend_d = (pend_q || load) && !commit;

    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_mask_d = act_mask_q;
    if (commit) begin
      act_data_d = sh_data_d;
      act_dp_d   = sh_dp_d;
      act_mask_d = sh_mask_d;
    end

    // Outputs are computed from next-cycle state so num/dp change exactly at
    // the start of a slot and hold for its whole duration.
    supp_d = suppressed(act_data_d, act_mask_d);
    num_d  = act_data_d[4*idx_d +: 4];
    dp_d   = act_dp_d[idx_d];
    dig_d  = DIG_OFF;
    if ((state_d == S_ON) && !supp_d[idx_d]) dig_d = DIG_OFF ^ (DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BLANK;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_mask_q <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_mask_q  <= '0;
      pend_q     <= 1'b0;
      num_q      <= 4'd0;
      dp_q       <= 1'b0;
      dig_q      <= DIG_OFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_mask_q <= act_mask_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_mask_q  <= sh_mask_d;
      pend_q     <= pend_d;
      num_q      <= num_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign num        = num_q;
  assign dp         = dp_q;
  assign dig        = dig_q;
  assign digit_idx  = idx_q;
  assign frame_done = boundary;
  assign load_ack   = commit;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomised and directed bench for sseg_scan_ctrl against a frame-position
// reference model (DIGITS=4, DIV=4, ON_TICKS=3, BLANK_TICKS=1).
module tb_sseg_scan_ctrl;
  localparam int D     = 4;
  localparam int DV    = 4;
  localparam int ONT   = 3;
  localparam int BLT   = 1;
  localparam int SLOT  = (BLT + ONT) * DV;
  localparam int FRAME = SLOT * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic        load_ack, dp, frame_done;
  logic [3:0]  num, dig;
  logic [1:0]  digit_idx;
  logic [12:0] obs;

  int          t;
  logic [15:0] m_data, s_data;
  logic [3:0]  m_dp, m_mask, s_dp, s_mask;
  bit          m_pend;
  logic [12:0] exp_v;
  int          vectors, miscompares;

  sseg_scan_ctrl #(
    .DIGITS(D), .DIV(DV), .ON_TICKS(ONT), .BLANK_TICKS(BLT), .INV_DIG(1), .LZS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp_in(dp_in),
    .blank_mask(blank_mask), .load_ack(load_ack), .num(num), .dp(dp), .dig(dig),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {dig, num, dp, digit_idx, frame_done, load_ack};

  function automatic void model_reset();
    t = 0;
    m_data = 16'h0; m_dp = 4'h0; m_mask = 4'h0;
    s_data = 16'h0; s_dp = 4'h0; s_mask = 4'h0;
    m_pend = 1'b0;
  endfunction

  // Expected outputs from the position inside the frame and the displayed set.
  function automatic void model_expect();
    int pos, idx, hi;
    bit on, sup, fire;
    logic [3:0] e_dig;
    pos = t % FRAME;
    idx = pos / SLOT;
    on  = (pos % SLOT) >= BLT * DV;
    hi  = -1;
    for (int k = 0; k < D; k++) if (m_data[4*k +: 4] != 4'd0) hi = k;
    sup   = m_mask[idx] || (idx != 0 && idx > hi);
    e_dig = (on && !sup) ? ~(4'b0001 << idx) : 4'b1111;
    fire  = en && (pos == FRAME - 1);
    exp_v = {e_dig, m_data[4*idx +: 4], m_dp[idx], 2'(idx), fire, fire && (m_pend || load)};
  endfunction

  function automatic void model_step();
    bit fire;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = en && (t % FRAME == FRAME - 1);
    if (load) begin
      s_data = data; s_dp = dp_in; s_mask = blank_mask; m_pend = 1'b1;
    end
    if (fire && m_pend) begin
      m_data = s_data; m_dp = s_dp; m_mask = s_mask; m_pend = 1'b0;
    end
    t = en ? t + 1 : 0;
  endfunction

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0; en = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF;
    model_reset();
    #1;
    vectors++;
    if (obs !== {4'b1111, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", obs, {4'b1111, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    repeat (3) begin
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_v);
      end
      adv();
    end
    load = 1'b0; data = 16'h0; dp_in = 4'h0; rst_n = 1'b1;
  endtask

  task automatic test_lzs_zero();
    int fd_cnt;
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL lzs_zero cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (frame_done === 1'b1) fd_cnt++;
      adv();
    end
    vectors++;
    if (fd_cnt != 2) begin
      miscompares++; $display("FAIL frame_done_count got=%0d exp=2", fd_cnt);
    end
  endtask

  task automatic test_load_1234();
    int acks;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      load = (i == 20);
      data = load ? 16'h1234 : 16'($urandom);
      dp_in = load ? 4'b0100 : 4'($urandom);
      blank_mask = load ? 4'b0000 : 4'($urandom);
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL load_1234 cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (load_ack === 1'b1) acks++;
      adv();
    end
    load = 1'b0;
    vectors++;
    if (acks != 1) begin
      miscompares++; $display("FAIL load_1234_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_a0_mask();
    for (int i = 0; i < 4 * FRAME; i++) begin
      load = (i == 5) || (i == 2 * FRAME + 5);
      data = load ? 16'h00A0 : 16'($urandom);
      dp_in = load ? 4'b0000 : 4'($urandom);
      blank_mask = (i == 2 * FRAME + 5) ? 4'b0010 : 4'b0000;
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL a0_mask cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      adv();
    end
    load = 1'b0; blank_mask = 4'h0;
  endtask

  task automatic test_multi_load();
    int acks;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      load = (i == 3) || (i == 10) || (i == 20);
      data = (i == 3) ? 16'h1111 : (i == 10) ? 16'h2222 : (i == 20) ? 16'h3333 : 16'($urandom);
      dp_in = 4'h0; blank_mask = 4'h0;
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL multi_load cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (load_ack === 1'b1) acks++;
      if (i == FRAME + 8) begin
        vectors++;
        if (num !== 4'h3) begin
          miscompares++; $display("FAIL multi_load_num got=%h exp=3", num);
        end
      end
      adv();
    end
    load = 1'b0;
    vectors++;
    if (acks != 1) begin
      miscompares++; $display("FAIL multi_load_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_boundary_load();
    for (int i = 0; i < 2 * FRAME; i++) begin
      load = (i == FRAME - 1);
      data = load ? 16'h5678 : 16'($urandom);
      dp_in = load ? 4'b1000 : 4'h0;
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL boundary_load cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if (i == FRAME - 1) begin
        vectors++;
        if (load_ack !== 1'b1) begin
          miscompares++; $display("FAIL boundary_ack got=%b exp=1", load_ack);
        end
      end
      if (i == FRAME + 4) begin
        vectors++;
        if (num !== 4'h8) begin
          miscompares++; $display("FAIL boundary_num got=%h exp=8", num);
        end
      end
      adv();
    end
    load = 1'b0;
  endtask

  task automatic test_en_toggle();
    for (int i = 0; i < 3 * FRAME; i++) begin
      en = !(i >= 8 && i < 18);
      load = (i == 12);
      data = load ? 16'h9ABC : 16'($urandom);
      dp_in = 4'h0;
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL en_toggle cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      if ((i == 9) || (i >= 18 && i < 22)) begin
        vectors++;
        if ({dig, digit_idx} !== {4'b1111, 2'd0}) begin
          miscompares++; $display("FAIL en_dark i=%0d got=%b_%0d exp=1111_0", i, dig, digit_idx);
        end
      end
      adv();
    end
    load = 1'b0; en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 99) < 97);
      load = ($urandom_range(0, 19) == 0);
      data = 16'($urandom);
      case ($urandom_range(0, 3))
        0: data &= 16'h00FF;
        1: data &= 16'h000F;
        2: data &= 16'h0F0F;
        default: ;
      endcase
      dp_in = 4'($urandom);
      blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL random cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      adv();
    end
    load = 1'b0; en = 1'b1; blank_mask = 4'h0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; data = 16'h0042; dp_in = 4'h1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      adv();
      load = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== {4'b1111, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_slot got=%h exp=%h", obs, {4'b1111, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk); model_expect(); vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      adv();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_lzs_zero();
    test_load_1234();
    test_a0_mask();
    test_multi_load();
    test_boundary_load();
    test_en_toggle();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
